spi_cmd_bridge: RTL and testbench

SPI slave front end that sits directly upstream of the pipeline head. It oversamples an external SPI link (mode 0, MSB first) in the system clock domain. Each received byte is pushed as a valid/ready byte stream into the command input. Response bytes from the command input are shifted back on MISO. A small receive FIFO absorbs back-pressure from the command parser.

---
 rtl/spi_cmd_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_cmd_bridge.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_bridge.sv
// SPI mode-0 slave bridge: oversamples the SPI link in the clk domain, pushes received bytes
// into a first-word-fall-through FIFO and shifts response bytes back out on MISO.
module spi_cmd_bridge #(
    parameter int SYNC_STAGES   = 2,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       cmd_m_valid,
    input  logic       cmd_m_ready,
    output logic [7:0] cmd_m_data,
    input  logic       cmd_s_valid,
    output logic       cmd_s_ready,
    input  logic [7:0] cmd_s_data,
    output logic       rx_overflow
);

    localparam int          AW      = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef logic [7:0] byte_t;
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_d_r;
    logic                   cs_d_r;
    logic                   sclk_rise_r;
    logic                   sclk_fall_r;
    logic                   cs_fall_r;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   clear_s;
    logic                   rx_step_s;
    logic                   byte_done_s;
    logic                   load_s;
    logic                   shift_s;

    logic [2:0]             bit_cnt_r;
    logic [6:0]             rx_shift_r;
    byte_t                  rx_byte_s;
    byte_t                  tx_shift_r;
    logic                   skip_r;
    logic                   miso_r;

    byte_t                  mem_r [RX_FIFO_DEPTH];
    logic [AW:0]            wptr_r;
    logic [AW:0]            rptr_r;
    logic                   empty_s;
    logic                   full_s;
    logic                   pop_s;
    logic                   wr_en_s;
    logic                   drop_s;
    logic                   overflow_r;

    assign sclk_s    = sclk_sync_r[SYNC_STAGES-1];
    assign cs_s      = cs_sync_r[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_r[SYNC_STAGES-1];
    assign rx_byte_s = {rx_shift_r, mosi_s};

    // Synchronizers plus registered edge pulses; cs resets as asserted so a frame already
    // in progress at reset release never produces a cs_fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_sync_r   <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_d_r    <= 1'b0;
            cs_d_r      <= 1'b0;
            sclk_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
            cs_fall_r   <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            sclk_d_r    <= sclk_s;
            cs_d_r      <= cs_s;
            sclk_rise_r <= sclk_s & ~sclk_d_r;
            sclk_fall_r <= ~sclk_s & sclk_d_r;
            cs_fall_r   <= ~cs_s & cs_d_r;
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        state_nxt_s = state_r;
        clear_s     = 1'b0;
        rx_step_s   = 1'b0;
        byte_done_s = 1'b0;
        load_s      = 1'b0;
        shift_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_r) begin
                    state_nxt_s = ST_ACTIVE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_nxt_s = ST_IDLE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                    rx_step_s   = sclk_rise_r;
                    if (sclk_rise_r && (bit_cnt_r == 3'd7)) begin
                        byte_done_s = 1'b1;
                        load_s      = 1'b1;
                    end else begin
                        byte_done_s = 1'b0;
                        load_s      = 1'b0;
                    end
                    if (sclk_fall_r && !skip_r) begin
                        shift_s = 1'b1;
                    end else begin
                        shift_s = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                clear_s     = 1'b1;
            end
        endcase
    end

    // Consume happens in the very cycle the response byte is sampled into tx_shift.
    assign cmd_s_ready = load_s & cmd_s_valid;

    // RX shifter, bit counter and TX shifter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 7'd0;
            tx_shift_r <= 8'h00;
            skip_r     <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            if (clear_s) begin
                bit_cnt_r  <= 3'd0;
                rx_shift_r <= 7'd0;
            end else if (rx_step_s) begin
                bit_cnt_r  <= bit_cnt_r + 3'd1;
                rx_shift_r <= rx_byte_s[6:0];
            end
            // A byte loaded on the completing rise must survive the fall that follows it;
            // a load at cs_fall has no such fall, so it does not arm the skip.
            if (load_s) begin
                tx_shift_r <= cmd_s_valid ? cmd_s_data : 8'h00;
                skip_r     <= byte_done_s;
            end else if (shift_s) begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                skip_r     <= 1'b0;
            end else if (sclk_fall_r) begin
                skip_r     <= 1'b0;
            end
            miso_r <= tx_shift_r[7];
        end
    end

    // FIFO status and handshake decode.
    always_comb begin
        empty_s = (wptr_r == rptr_r);
        full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        pop_s   = ~empty_s & cmd_m_ready;
        wr_en_s = byte_done_s & (~full_s | pop_s);
        drop_s  = byte_done_s & full_s & ~pop_s;
    end

    // Receive FIFO storage, pointers and sticky overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r     <= {(AW + 1){1'b0}};
            rptr_r     <= {(AW + 1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                mem_r[wptr_r[AW-1:0]] <= rx_byte_s;
                wptr_r                <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign cmd_m_valid = ~empty_s;
    assign cmd_m_data  = mem_r[rptr_r[AW-1:0]];
    assign spi_miso    = miso_r;
    assign rx_overflow = overflow_r;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Directed bench for spi_cmd_bridge: table of single-byte frames plus hand-written
// sequences for timing, overflow, simultaneous push/pop, partial bytes and reset.
module tb_spi_cmd_bridge;

    localparam int S     = 2;
    localparam int DEPTH = 16;

    logic       clk         = 1'b0;
    logic       rstn        = 1'b0;
    logic       spi_sclk    = 1'b0;
    logic       spi_cs_n    = 1'b1;
    logic       spi_mosi    = 1'b0;
    logic       cmd_m_ready = 1'b0;
    logic       cmd_s_valid = 1'b0;
    logic [7:0] cmd_s_data  = 8'h00;
    logic       spi_miso;
    logic       cmd_m_valid;
    logic [7:0] cmd_m_data;
    logic       cmd_s_ready;
    logic       rx_overflow;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         s_pulses = 0;
    int         s_bad    = 0;
    logic [7:0] rx_q [$];
    time        rx_t [$];
    time        t_rise_last;

    typedef struct {
        logic [7:0] mosi;
        logic       s_valid;
        logic [7:0] s_data;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_pulses;
    } vec_t;
    vec_t vecs [6];

    spi_cmd_bridge #(.SYNC_STAGES(S), .RX_FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .cmd_m_valid(cmd_m_valid),
        .cmd_m_ready(cmd_m_ready),
        .cmd_m_data (cmd_m_data),
        .cmd_s_valid(cmd_s_valid),
        .cmd_s_ready(cmd_s_ready),
        .cmd_s_data (cmd_s_data),
        .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    // Observe both streams mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rstn && cmd_m_valid && cmd_m_ready) begin
            rx_q.push_back(cmd_m_data);
            rx_t.push_back($time);
        end
        if (cmd_s_ready) s_pulses <= s_pulses + 1;
        if (cmd_s_ready && !cmd_s_valid) s_bad <= s_bad + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " spi_miso"},    {31'd0, spi_miso},    32'd0);
        check({tag, " cmd_m_valid"}, {31'd0, cmd_m_valid}, 32'd0);
        check({tag, " cmd_m_data"},  {24'd0, cmd_m_data},  32'd0);
        check({tag, " cmd_s_ready"}, {31'd0, cmd_s_ready}, 32'd0);
        check({tag, " rx_overflow"}, {31'd0, rx_overflow}, 32'd0);
    endtask

    // Sends the top nbits of b MSB first (sclk = clk/8) and samples MISO late in each high phase.
    task automatic spi_bits(input logic [7:0] b, input int nbits, input logic pop_last,
                            output logic [7:0] m);
        m = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = b[i];
            cyc(4);
            spi_sclk    = 1'b1;
            t_rise_last = $time;
            cyc(3);
            m[i] = spi_miso;
            if (i == 7) cmd_s_valid = 1'b0;
            if (pop_last && i == 0) cmd_m_ready = 1'b1;
            cyc(1);
            if (pop_last && i == 0) cmd_m_ready = 1'b0;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] tx, input logic sv, input logic [7:0] sd,
                         output logic [7:0] m);
        cmd_s_valid = sv;
        cmd_s_data  = sd;
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(8);
        spi_bits(tx, 8, 1'b0, m);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
    endtask

    initial begin
        logic [7:0] m;
        int         base;
        int         p0;

        vecs[0] = '{8'hA5, 1'b1, 8'h3C, 8'hA5, 8'h3C, 1};
        vecs[1] = '{8'h00, 1'b1, 8'h3C, 8'h00, 8'h3C, 1};
        vecs[2] = '{8'h00, 1'b0, 8'h3C, 8'h00, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 8'h81, 8'hFF, 8'h81, 1};
        vecs[4] = '{8'h5A, 1'b0, 8'hFF, 8'h5A, 8'h00, 0};
        vecs[5] = '{8'h81, 1'b1, 8'h00, 8'h81, 8'h00, 1};

        cyc(4);
        check_reset_outputs("in_reset");
        rstn = 1'b1;
        cyc(3);
        check_reset_outputs("after_reset");

        // First MISO bit appears S+3 cycles after the cs_n fall.
        cmd_m_ready = 1'b1;
        cmd_s_valid = 1'b1;
        cmd_s_data  = 8'hC3;
        p0          = s_pulses;
        base        = rx_q.size();
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(S + 2);
        check("miso_before_first_bit", {31'd0, spi_miso}, 32'd0);
        cyc(1);
        check("miso_first_bit", {31'd0, spi_miso}, 32'd1);
        spi_bits(8'h00, 8, 1'b0, m);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
        check("miso_c3_byte", {24'd0, m}, 32'hC3);
        check("c3_pulses", s_pulses - p0, 32'd1);
        check("c3_rx_beats", rx_q.size() - base, 32'd1);

        for (int i = 0; i < 6; i++) begin
            p0   = s_pulses;
            base = rx_q.size();
            frame(vecs[i].mosi, vecs[i].s_valid, vecs[i].s_data, m);
            check($sformatf("vec%0d_miso", i), {24'd0, m}, {24'd0, vecs[i].exp_miso});
            check($sformatf("vec%0d_pulses", i), s_pulses - p0, vecs[i].exp_pulses);
            if (rx_q.size() == base + 1) begin
                check($sformatf("vec%0d_rx", i), {24'd0, rx_q[base]}, {24'd0, vecs[i].exp_rx});
                if (i == 0) check("rx_latency", 32'(rx_t[base] - t_rise_last), (S + 2) * 10 + 4);
            end else begin
                check($sformatf("vec%0d_rx_count", i), rx_q.size() - base, 32'd1);
            end
        end

        // Partial byte followed by a full 0x81.
        base = rx_q.size();
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(8);
        spi_bits(8'hFF, 5, 1'b0, m);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
        frame(8'h81, 1'b0, 8'h00, m);
        check("partial_count", rx_q.size() - base, 32'd1);
        if (rx_q.size() > base) check("partial_data", {24'd0, rx_q[base]}, 32'h81);

        // Back-pressure: 17 bytes into a 16-entry FIFO.
        cmd_m_ready = 1'b0;
        base        = rx_q.size();
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(8);
        for (int k = 0; k < 17; k++) begin
            spi_bits(8'(k), 8, 1'b0, m);
            if (k == 15) check("ovf_before_17th", {31'd0, rx_overflow}, 32'd0);
        end
        check("ovf_set", {31'd0, rx_overflow}, 32'd1);
        check("ovf_head_valid", {31'd0, cmd_m_valid}, 32'd1);
        check("ovf_head_data", {24'd0, cmd_m_data}, 32'h00);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
        check("ovf_no_pop", rx_q.size() - base, 32'd0);
        cmd_m_ready = 1'b1;
        cyc(20);
        check("ovf_beats", rx_q.size() - base, 32'd16);
        if (rx_q.size() >= base + 16) begin
            for (int j = 0; j < 16; j++) check($sformatf("ovf_data%0d", j), {24'd0, rx_q[base+j]}, j);
            check("drain_rate", 32'(rx_t[base+15] - rx_t[base]), 32'd150);
        end
        check("ovf_sticky", {31'd0, rx_overflow}, 32'd1);

        // Full FIFO with a pop in the same cycle as the push.
        rstn = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(2);
        check("ovf_cleared", {31'd0, rx_overflow}, 32'd0);
        cmd_m_ready = 1'b0;
        base        = rx_q.size();
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(8);
        for (int k = 0; k < 16; k++) spi_bits(8'h20 + 8'(k), 8, 1'b0, m);
        spi_bits(8'h55, 8, 1'b1, m);
        check("simul_no_ovf", {31'd0, rx_overflow}, 32'd0);
        check("simul_one_pop", rx_q.size() - base, 32'd1);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
        cmd_m_ready = 1'b1;
        cyc(24);
        check("simul_beats", rx_q.size() - base, 32'd17);
        if (rx_q.size() >= base + 17) begin
            for (int j = 0; j < 16; j++) check($sformatf("simul_data%0d", j), {24'd0, rx_q[base+j]}, 32'h20 + j);
            check("simul_last", {24'd0, rx_q[base+16]}, 32'h55);
        end

        // Asynchronous reset in the middle of a byte.
        cmd_m_ready = 1'b0;
        frame(8'h11, 1'b0, 8'h00, m);
        cmd_s_valid = 1'b1;
        cmd_s_data  = 8'hFF;
        cyc(2);
        spi_cs_n = 1'b0;
        cyc(8);
        spi_bits(8'h00, 4, 1'b0, m);
        check("pre_rst_miso", {31'd0, spi_miso}, 32'd1);
        check("pre_rst_valid", {31'd0, cmd_m_valid}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_byte_reset");
        cyc(3);
        rstn = 1'b1;
        cyc(4);
        cmd_m_ready = 1'b1;
        base        = rx_q.size();
        spi_bits(8'hAA, 8, 1'b0, m);
        cyc(4);
        spi_cs_n = 1'b1;
        cyc(8);
        check("stale_frame_ignored", rx_q.size() - base, 32'd0);
        frame(8'h7E, 1'b0, 8'h00, m);
        check("post_rst_count", rx_q.size() - base, 32'd1);
        if (rx_q.size() > base) check("post_rst_data", {24'd0, rx_q[base]}, 32'h7E);

        check("s_ready_without_valid", s_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
